// File: rtl/t5_mdsu_if.sv
// Decode-side bus of the iterative multiply/divide unit: request, operands, stall and result.
interface t5_mdsu_if #(parameter int XLEN = 32);
    logic            sena;
    logic            dreq;
    logic            dkil;
    logic [2:0]      dfn3;
    logic [XLEN-1:0] dop1;
    logic [XLEN-1:0] dop2;
    logic            xstl;
    logic [XLEN-1:0] mres;
    logic            mvld;

    modport master (output sena, dreq, dkil, dfn3, dop1, dop2,
                    input  xstl, mres, mvld);
    modport slave  (input  sena, dreq, dkil, dfn3, dop1, dop2,
                    output xstl, mres, mvld);
endinterface

// File: rtl/t5_mdsu.sv
// Iterative RV32M/RV64M multiply/divide unit: shift-add multiply and restoring divide on
// unsigned magnitudes, UNROLL bits per cycle, with sign fix-up applied to the final result.
module t5_mdsu #(
    parameter int XLEN   = 32,
    parameter int UNROLL = 1
) (
    input  logic       sclk,
    input  logic       srst,
    t5_mdsu_if.slave   bus
);
    localparam int STEPS = XLEN / UNROLL;
    localparam int CW    = $clog2(STEPS + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t              r_state;
    logic [CW-1:0]       r_cnt;
    logic [2*XLEN-1:0]   r_acc;
    logic [XLEN-1:0]     r_a;
    logic [XLEN-1:0]     r_b;
    logic [XLEN-1:0]     r_mres;
    logic [2:0]          r_fn;
    logic                r_neg;
    logic                r_mvld;

    logic                w_div, w_sg1, w_sg2, w_s1, w_s2, w_dz, w_neg;
    logic [XLEN-1:0]     w_m1, w_m2;
    logic [2*XLEN-1:0]   w_acc, w_prod;
    logic [XLEN-1:0]     w_b, w_q, w_r, w_res;
    logic [XLEN:0]       w_sh, w_sub;

    // Request decode: which operands are signed, their magnitudes and the result sign.
    always_comb begin
        case (bus.dfn3)
            3'd0, 3'd1, 3'd4, 3'd6: {w_sg1, w_sg2} = 2'b11;
            3'd2:                   {w_sg1, w_sg2} = 2'b10;
            default:                {w_sg1, w_sg2} = 2'b00;
        endcase
        w_div = bus.dfn3[2];
        w_s1  = w_sg1 & bus.dop1[XLEN-1];
        w_s2  = w_sg2 & bus.dop2[XLEN-1];
        w_m1  = w_s1 ? -bus.dop1 : bus.dop1;
        w_m2  = w_s2 ? -bus.dop2 : bus.dop2;
        w_dz  = w_div & (bus.dop2 == '0);
        w_neg = (w_div & bus.dfn3[1]) ? w_s1 : ((w_s1 ^ w_s2) & ~w_dz);
    end

    // UNROLL iterations per cycle. Multiply consumes multiplier bits MSB first into a
    // left-shifting accumulator; divide shifts {rem, quotient} left and trial-subtracts.
    always_comb begin
        w_acc = r_acc;
        w_b   = r_b;
        w_sh  = '0;
        w_sub = '0;
        for (int i = 0; i < UNROLL; i++) begin
            if (r_fn[2]) begin
                w_sh  = w_acc[2*XLEN-1:XLEN-1];
                w_sub = w_sh - {1'b0, r_a};
                if (!w_sub[XLEN])
                    w_acc = {w_sub[XLEN-1:0], w_acc[XLEN-2:0], 1'b1};
                else
                    w_acc = {w_acc[2*XLEN-2:0], 1'b0};
            end else begin
                w_acc = (w_acc << 1) + (w_b[XLEN-1] ? {{XLEN{1'b0}}, r_a} : '0);
                w_b   = w_b << 1;
            end
        end
    end

    // Product negated across the full double width before the high/low select.
    always_comb begin
        w_prod = r_neg ? -w_acc : w_acc;
        w_q    = w_acc[XLEN-1:0];
        w_r    = w_acc[2*XLEN-1:XLEN];
        case (r_fn)
            3'd0:             w_res = w_prod[XLEN-1:0];
            3'd1, 3'd2, 3'd3: w_res = w_prod[2*XLEN-1:XLEN];
            3'd4, 3'd5:       w_res = r_neg ? -w_q : w_q;
            default:          w_res = r_neg ? -w_r : w_r;
        endcase
    end

    always_ff @(posedge sclk or negedge srst) begin
        if (!srst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_mres  <= '0;
            r_fn    <= '0;
            r_neg   <= 1'b0;
            r_mvld  <= 1'b0;
        end else if (bus.sena) begin
            r_mvld <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.dreq && !bus.dkil) begin
                        r_fn  <= bus.dfn3;
                        r_neg <= w_neg;
                        if (w_dz) begin
                            r_state <= S_DONE;
                            r_mvld  <= 1'b1;
                            r_mres  <= bus.dfn3[1] ? bus.dop1 : '1;
                        end else begin
                            r_state <= S_RUN;
                            r_cnt   <= CW'(STEPS);
                            if (w_div) begin
                                r_acc <= {{XLEN{1'b0}}, w_m1};
                                r_a   <= w_m2;
                                r_b   <= '0;
                            end else begin
                                r_acc <= '0;
                                r_a   <= w_m1;
                                r_b   <= w_m2;
                            end
                        end
                    end
                end
                S_RUN: begin
                    if (bus.dkil) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_acc <= w_acc;
                        r_b   <= w_b;
                        r_cnt <= r_cnt - 1'b1;
                        if (r_cnt == CW'(1)) begin
                            r_state <= S_DONE;
                            r_mvld  <= 1'b1;
                            r_mres  <= w_res;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.xstl = (r_state == S_RUN) |
                      ((r_state == S_IDLE) & bus.dreq & bus.sena & ~bus.dkil);
    assign bus.mres = r_mres;
    assign bus.mvld = r_mvld;
endmodule

// File: tb/tb_t5_mdsu.sv
// Scoreboard bench for t5_mdsu: three configurations (32/1, 32/4, 64/2) with directed vectors.
module tb_t5_mdsu;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   nchk = 0;
    int   nfail = 0;

    typedef struct {
        string       nm;
        logic [63:0] res;
        int          cyc;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    t5_mdsu_if #(.XLEN(32)) if0();
    t5_mdsu_if #(.XLEN(32)) if1();
    t5_mdsu_if #(.XLEN(64)) if2();

    t5_mdsu #(.XLEN(32), .UNROLL(1)) u0 (.sclk(clk), .srst(rst_n), .bus(if0));
    t5_mdsu #(.XLEN(32), .UNROLL(4)) u1 (.sclk(clk), .srst(rst_n), .bus(if1));
    t5_mdsu #(.XLEN(64), .UNROLL(2)) u2 (.sclk(clk), .srst(rst_n), .bus(if2));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        nchk++;
        if (act !== req) begin
            nfail++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    // Monitors: pop the oldest expectation whenever a unit presents a sena-qualified result.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && if0.sena && if0.mvld) begin
            if (q0.size() == 0) chk("u0_unexpected_mvld", 64'(cyc), 64'(-1));
            else begin
                e = q0.pop_front();
                chk(e.nm, {32'b0, if0.mres}, e.res);
                chk({e.nm, "_cyc"}, 64'(cyc), 64'(e.cyc));
                chk({e.nm, "_xstl_done"}, 64'(if0.xstl), 64'd0);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && if1.sena && if1.mvld) begin
            if (q1.size() == 0) chk("u1_unexpected_mvld", 64'(cyc), 64'(-1));
            else begin
                e = q1.pop_front();
                chk(e.nm, {32'b0, if1.mres}, e.res);
                chk({e.nm, "_cyc"}, 64'(cyc), 64'(e.cyc));
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && if2.sena && if2.mvld) begin
            if (q2.size() == 0) chk("u2_unexpected_mvld", 64'(cyc), 64'(-1));
            else begin
                e = q2.pop_front();
                chk(e.nm, if2.mres, e.res);
                chk({e.nm, "_cyc"}, 64'(cyc), 64'(e.cyc));
            end
        end
    end

    // Drive one request for one cycle and push its expected result and arrival cycle.
    task automatic issue(input int d, input logic [2:0] fn, input logic [63:0] a,
                         input logic [63:0] b, input logic [63:0] res, input int lat,
                         input string nm);
        exp_t e;
        @(posedge clk); #1;
        e.nm = nm; e.res = res; e.cyc = cyc + lat;
        case (d)
            0: begin
                if0.dfn3 = fn; if0.dop1 = a[31:0]; if0.dop2 = b[31:0]; if0.dreq = 1'b1;
                q0.push_back(e);
                #1 chk({nm, "_xstl_req"}, 64'(if0.xstl), 64'd1);
            end
            1: begin
                if1.dfn3 = fn; if1.dop1 = a[31:0]; if1.dop2 = b[31:0]; if1.dreq = 1'b1;
                q1.push_back(e);
            end
            default: begin
                if2.dfn3 = fn; if2.dop1 = a; if2.dop2 = b; if2.dreq = 1'b1;
                q2.push_back(e);
            end
        endcase
        @(posedge clk); #1;
        if0.dreq = 1'b0; if1.dreq = 1'b0; if2.dreq = 1'b0;
    endtask

    // Wait until the given unit's queue drains; counts cycles with u0 stalled.
    task automatic wait_done(input int d, output int stl);
        int sz;
        bit done;
        stl = 0;
        done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk); #1;
            if (if0.xstl) stl++;
            sz = (d == 0) ? q0.size() : (d == 1) ? q1.size() : q2.size();
            if (sz == 0) done = 1'b1;
        end
        if (!done) chk("wait_done_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        int stl;
        if0.sena = 1'b1; if0.dreq = 1'b0; if0.dkil = 1'b0; if0.dfn3 = '0; if0.dop1 = '0; if0.dop2 = '0;
        if1.sena = 1'b1; if1.dreq = 1'b0; if1.dkil = 1'b0; if1.dfn3 = '0; if1.dop1 = '0; if1.dop2 = '0;
        if2.sena = 1'b1; if2.dreq = 1'b0; if2.dkil = 1'b0; if2.dfn3 = '0; if2.dop1 = '0; if2.dop2 = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mres", {32'b0, if0.mres}, 64'd0);
        chk("rst_mvld", 64'(if0.mvld), 64'd0);
        chk("rst_xstl", 64'(if0.xstl), 64'd0);
        rst_n = 1'b1;

        issue(0, 3'd0, 64'd7, 64'hFFFFFFFD, 64'hFFFFFFEB, 33, "mul_7_m3");
        wait_done(0, stl);
        chk("mul_stall_cycles", 64'(stl), 64'd32);

        issue(0, 3'd3, 64'hFFFFFFFF, 64'hFFFFFFFF, 64'hFFFFFFFE, 33, "mulhu_ones"); wait_done(0, stl);
        issue(0, 3'd1, 64'hFFFFFFFF, 64'hFFFFFFFF, 64'h00000000, 33, "mulh_m1");    wait_done(0, stl);
        issue(0, 3'd2, 64'hFFFFFFFF, 64'hFFFFFFFF, 64'hFFFFFFFF, 33, "mulhsu_m1");  wait_done(0, stl);
        issue(0, 3'd4, 64'hFFFFFFF9, 64'd2, 64'hFFFFFFFD, 33, "div_m7_2");          wait_done(0, stl);
        issue(0, 3'd6, 64'hFFFFFFF9, 64'd2, 64'hFFFFFFFF, 33, "rem_m7_2");          wait_done(0, stl);
        issue(0, 3'd5, 64'hFFFFFFF9, 64'd2, 64'h7FFFFFFC, 33, "divu_fff9_2");       wait_done(0, stl);
        issue(0, 3'd7, 64'hFFFFFFF9, 64'd2, 64'h00000001, 33, "remu_fff9_2");       wait_done(0, stl);
        issue(0, 3'd5, 64'd5, 64'd0, 64'hFFFFFFFF, 1, "divu_by0");                  wait_done(0, stl);
        issue(0, 3'd6, 64'd5, 64'd0, 64'd5, 1, "rem_by0");                          wait_done(0, stl);
        issue(0, 3'd4, 64'h80000000, 64'hFFFFFFFF, 64'h80000000, 33, "div_ovf");    wait_done(0, stl);
        issue(0, 3'd6, 64'h80000000, 64'hFFFFFFFF, 64'h00000000, 33, "rem_ovf");    wait_done(0, stl);

        issue(1, 3'd4, 64'd100, 64'd7, 64'd14, 9, "u4_div_100_7");                  wait_done(1, stl);
        issue(2, 3'd3, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF,
              64'hFFFFFFFFFFFFFFFE, 33, "x64_mulhu_ones");                             wait_done(2, stl);

        // Flush in cycle 10 of a DIV; the replacement request in cycle 12 must complete.
        @(posedge clk); #1;
        if0.dfn3 = 3'd4; if0.dop1 = 32'd100; if0.dop2 = 32'd7; if0.dreq = 1'b1;
        @(posedge clk); #1;
        if0.dreq = 1'b0;
        repeat (9) @(posedge clk);
        #1 if0.dkil = 1'b1;
        @(posedge clk); #1;
        if0.dkil = 1'b0;
        chk("kill_idle_xstl", 64'(if0.xstl), 64'd0);
        issue(0, 3'd5, 64'd200, 64'd7, 64'd28, 33, "divu_after_kill");
        wait_done(0, stl);

        // Reset asserted in cycle 5 of a MUL clears outputs at once and drops the op.
        @(posedge clk); #1;
        if0.dfn3 = 3'd0; if0.dop1 = 32'd3; if0.dop2 = 32'd5; if0.dreq = 1'b1;
        @(posedge clk); #1;
        if0.dreq = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_mres", {32'b0, if0.mres}, 64'd0);
        chk("midrst_mvld", 64'(if0.mvld), 64'd0);
        chk("midrst_xstl", 64'(if0.xstl), 64'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (40) @(posedge clk);

        // Three disabled cycles mid-RUN push the result out by exactly three cycles.
        issue(0, 3'd4, 64'd100, 64'd7, 64'd14, 36, "div_sena_hold");
        repeat (4) @(posedge clk);
        #1 if0.sena = 1'b0;
        repeat (3) @(posedge clk);
        #1 if0.sena = 1'b1;
        wait_done(0, stl);

        repeat (5) @(posedge clk);
        if (q0.size() != 0 || q1.size() != 0 || q2.size() != 0)
            chk("pending_at_end", 64'(q0.size() + q1.size() + q2.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
        $finish;
    end
endmodule

// File: doc/t5_mdsu.md
Name: t5_mdsu

Overview:
Iterative multiply/divide execute unit covering the RV32M/RV64M funct3 set. It sits beside the single-cycle ALU/shift/branch execute stage and is issued from decode with the same operand buses. It holds the pipeline through a stall output until the result is ready. It is parametrised in data width and in bits retired per cycle (radix).

Parameters:
XLEN, 32, datapath width; 32 or 64.
UNROLL, 1, quotient/multiplier bits processed per cycle; one of 1, 2, 4; must divide XLEN.

Ports:
sclk  input  1  clock, rising edge.
srst  input  1  reset; asynchronous assert, active-low.
sena  input  1  pipeline enable; when low, all state and outputs hold.
dreq  input  1  M-extension op valid in decode (opcode OP, funct7 = 0000001).
dkil  input  1  flush; aborts any operation in flight.
dfn3  input  3  funct3 [14:12]: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
dop1  input  XLEN  rs1 operand.
dop2  input  XLEN  rs2 operand.
xstl  output 1  stall request to the pipeline.
mres  output XLEN  result.
mvld  output 1  result valid, one-cycle pulse.

Behaviour:
- Reset: state IDLE; mres = 0, mvld = 0, xstl = 0; all internal accumulators and the counter = 0. Reset mid-operation abandons the operation with no mvld.
- States:
  - IDLE: accepts dreq when sena=1 and dkil=0. Latches the op and operand magnitudes (signed ops take |x|; the sign of rs2 is ignored for MULHSU). Records the result sign.
  - From IDLE, go to RUN; if the op is a divide/remainder and dop2 = 0, go directly to DONE.
  - RUN: the counter loads XLEN/UNROLL and decrements each enabled cycle.
    - Multiply: shift-add on a 2*XLEN accumulator, UNROLL bits per cycle.
    - Divide: restoring division, UNROLL quotient bits per cycle.
    - When the counter reaches 1, the next edge goes to DONE and registers the sign-fixed mres.
  - DONE: mvld = 1 for exactly one cycle; next edge goes to IDLE.
- xstl:
  - Combinationally 1 in IDLE when dreq & sena & !dkil.
  - 1 throughout RUN.
  - 0 in DONE, so the pipeline advances in the same cycle mres is consumed.
- Latency: call the request cycle cycle 0. mvld is high in cycle XLEN/UNROLL + 1 (33 for 32/1; 9 for 32/4). Divide-by-zero has mvld in cycle 1.
- Result selection:
  - MUL: low XLEN bits of the product.
  - MULH, MULHSU, MULHU: high XLEN bits of the product.
  - DIV, DIVU: quotient.
  - REM, REMU: remainder.
  - Negation is two's-complement across the full 2*XLEN product before the high/low select.
- Sign rules:
  - Quotient is negative iff the operand signs differ and the divisor is nonzero.
  - Remainder takes the sign of the dividend.
- Divide by zero: quotient = all ones, remainder = dividend (unsigned and signed alike).
- Signed overflow (dividend = -2^(XLEN-1), divisor = -1): quotient = -2^(XLEN-1), remainder = 0. The normal path must produce this without a special case; the bench checks it.
- dkil:
  - In RUN or DONE, the next enabled edge goes to IDLE with mvld = 0.
  - dkil and dreq together in IDLE: the request is ignored.
- sena = 0: the counter, state, mvld and mres all freeze. An mvld pulse is therefore stretched until sena returns; the consumer samples it qualified by sena.
- dreq while not IDLE is ignored; the pipeline guarantees this cannot happen while xstl = 1.
- mres holds its last value after DONE until the next DONE.

Test Plan:
- MUL 7 × 0xFFFFFFFD (-3), XLEN=32, UNROLL=1 -> mres = 0xFFFFFFEB, mvld in cycle 33, xstl high in cycles 0–32.
- MULHU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFE; MULH same operands -> 0x00000000; MULHSU 0xFFFFFFFF (-1) × 0xFFFFFFFF -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD; REM -> 0xFFFFFFFF; DIVU 0xFFFFFFF9 / 2 -> 0x7FFFFFFC; REMU -> 1.
- DIVU 5/0 -> 0xFFFFFFFF and REM 5/0 -> 5, mvld in cycle 1; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000, REM -> 0.
- UNROLL=4: DIV 100/7 -> 14 in cycle 9. XLEN=64, UNROLL=2: MULHU (2^64-1)^2 -> 0xFFFFFFFFFFFFFFFE in cycle 33.
- Control:
  - dkil in cycle 10 of a DIV -> IDLE, no mvld; a new request in cycle 12 completes correctly.
  - srst low in cycle 5 -> all outputs 0 immediately.
  - sena low for 3 cycles mid-RUN -> mvld delayed by exactly 3 cycles, same result.
